ex_mem_flag_stage: RTL and testbench
====================================

Name: ex_mem_flag_stage

Overview:
- EX/MEM boundary stage, directly downstream of adder_multifunc_16bit and the rest of the execute datapath.
- Registers the ALU result, overflow and writeback control into the MEM stage.
- Owns the architectural Z/V/N flag register, with per-opcode update rules.
- Evaluates the 3-bit branch condition against the flags for the branch unit.

Parameters:
DATA_W, 16, ALU result width
REG_ADDR_W, 4, register-file address width
FLAG_BYPASS, 0, 1 = branch_taken sees flags being written this cycle; 0 = registered flags only

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold all stage registers and flags
flush  input  1  squash the EX instruction: bubble into MEM, no flag update
ex_valid  input  1  EX holds a real instruction
ex_opcode  input  4  instruction opcode (shared package encoding)
ex_alu_result  input  DATA_W  result from execute datapath (saturated for ADD/SUB/PADDSB)
ex_ovfl  input  1  overflow indication from adder
ex_dst_reg  input  REG_ADDR_W  destination register
ex_reg_wen  input  1  instruction writes the register file
cond_code  input  3  branch condition under evaluation
mem_valid  output  1  MEM stage holds a real instruction
mem_alu_result  output  DATA_W  registered ALU result
mem_dst_reg  output  REG_ADDR_W  registered destination
mem_reg_wen  output  1  registered write enable, forced 0 when mem_valid=0
flag_z  output  1  zero flag
flag_v  output  1  overflow flag
flag_n  output  1  negative flag
branch_taken  output  1  combinational condition result

Behaviour:
- Reset (rst=1 at an edge): mem_valid=0, mem_alu_result=0, mem_dst_reg=0, mem_reg_wen=0, flag_z=0, flag_v=0, flag_n=0. rst overrides stall and flush.
- Advance condition: adv = !stall.
- Priority, highest first: rst > flush > stall > normal.
- Normal (adv, !flush): capture all EX fields next edge (latency 1 cycle).
  - mem_valid <= ex_valid.
  - mem_reg_wen <= ex_reg_wen & ex_valid.
- Flush (adv or not): mem_valid <= 0, mem_reg_wen <= 0; data/dst fields are don't-care but are held. Flags are not updated.
- Stall without flush: every register holds its value; no flag update even if ex_valid.
- Flag update occurs only when adv & !flush & ex_valid. The update is selected by opcode:
  - ADD (0000), SUB (0001): Z <= (result==0), N <= result[15], V <= ex_ovfl.
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): Z only; V and N hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): no flag change.
- Condition codes, evaluated on the effective flags (z, v, n):
  - 000 NEQ: !z
  - 001 EQ: z
  - 010 GT: !z & !n
  - 011 LT: n
  - 100 GTE: z | (!z & !n)
  - 101 LTE: n | z
  - 110 OVFL: v
  - 111 UNCOND: 1
- Effective flags:
  - FLAG_BYPASS=0: the registered flags.
  - FLAG_BYPASS=1: the next-state flags whenever a flag update qualifies this cycle, else the registered flags.
- branch_taken is purely combinational; there is no path from mem_* outputs to it.
- Back-to-back flag writers: the second update overwrites the first, per field, following the rules above. For example, XOR after SUB keeps V/N from the SUB and takes Z from the XOR.

Decomposition:
- Shared package (wisc_pkg):
  - opcode_t enum, 4-bit, encodings as above.
  - cond_t enum, 3-bit.
  - flags_t packed struct {z, v, n}.
  - Constants DATA_W and REG_ADDR_W.
- One sub-module, branch_cond_eval: combinational, takes flags_t and cond_t, produces taken. It is reused by the ID-stage branch unit.
- Flag next-state logic stays inline.

Test Plan:
- Reset: hold rst=1 for 2 cycles with ex_valid=1, ADD, result 16'h0000 → all outputs 0; flags 000 after release, before any edge with qualifying input.
- ADD result 16'h8000, ovfl=1, dst=5, wen=1 → next cycle:
  - mem_alu_result=16'h8000, mem_dst_reg=5, mem_reg_wen=1, mem_valid=1.
  - z=0, v=1, n=1; cond 011 → taken=1; cond 110 → taken=1.
- SUB result 16'h0000, ovfl=0, then XOR result 16'h00FF next cycle:
  - After SUB: z=1, v=0, n=0.
  - After XOR: z=0, v=0, n=0.
  - cond 010 → taken=1.
- RED result 16'h0000 and PADDSB result 16'h0000 issued after flags z=0 n=1 → flags unchanged; cond 101 → taken=1.
- Stall 3 cycles with new ADD (result 0) presented → MEM regs and flags frozen. Release → captured next edge, z=1.
- flush and stall both high with ADD result 0 → mem_valid=0, mem_reg_wen=0, flags unchanged. Repeat with FLAG_BYPASS=1: branch_taken on cond 001 reflects the old z, not 1.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared opcode, condition-code and flag types for the WISC pipeline.
package wisc_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        CC_NEQ    = 3'b000,
        CC_EQ     = 3'b001,
        CC_GT     = 3'b010,
        CC_LT     = 3'b011,
        CC_GTE    = 3'b100,
        CC_LTE    = 3'b101,
        CC_OVFL   = 3'b110,
        CC_UNCOND = 3'b111
    } cond_t;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator; shared with the ID-stage branch unit.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  flags_t flags,
    input  cond_t  cond,
    output logic   taken
);

    // Map each condition code onto the Z/V/N flags.
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_NEQ:    taken = !flags.z;
            CC_EQ:     taken = flags.z;
            CC_GT:     taken = !flags.z && !flags.n;
            CC_LT:     taken = flags.n;
            CC_GTE:    taken = flags.z || (!flags.z && !flags.n);
            CC_LTE:    taken = flags.n || flags.z;
            CC_OVFL:   taken = flags.v;
            CC_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register plus the architectural Z/V/N flag register and
// branch-condition evaluation for the branch unit.
module ex_mem_flag_stage #(
    parameter int DATA_W      = wisc_pkg::DATA_W,
    parameter int REG_ADDR_W  = wisc_pkg::REG_ADDR_W,
    parameter bit FLAG_BYPASS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [3:0]            ex_opcode,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic                  ex_ovfl,
    input  logic [REG_ADDR_W-1:0] ex_dst_reg,
    input  logic                  ex_reg_wen,
    input  logic [2:0]            cond_code,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_alu_result,
    output logic [REG_ADDR_W-1:0] mem_dst_reg,
    output logic                  mem_reg_wen,
    output logic                  flag_z,
    output logic                  flag_v,
    output logic                  flag_n,
    output logic                  branch_taken
);

    import wisc_pkg::*;

    logic                  valid_q,  valid_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic [REG_ADDR_W-1:0] dst_q,    dst_d;
    logic                  wen_q,    wen_d;
    flags_t                flags_q,  flags_d;
    flags_t                flags_eff;
    logic                  adv;
    logic                  flag_upd;

    assign adv      = !stall;
    assign flag_upd = adv && !flush && ex_valid;

    // Stage-register next state: flush bubbles (data held), stall holds, else capture.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        dst_d    = dst_q;
        wen_d    = wen_q;
        if (flush) begin
            valid_d = 1'b0;
            wen_d   = 1'b0;
        end else if (adv) begin
            valid_d  = ex_valid;
            result_d = ex_alu_result;
            dst_d    = ex_dst_reg;
            wen_d    = ex_reg_wen && ex_valid;
        end
    end

    // Flag next state: arithmetic ops set all three, logic/shift ops set Z only.
    always_comb begin
        flags_d = flags_q;
        if (flag_upd) begin
            case (opcode_t'(ex_opcode))
                OP_ADD, OP_SUB: begin
                    flags_d.z = (ex_alu_result == '0);
                    flags_d.n = ex_alu_result[DATA_W-1];
                    flags_d.v = ex_ovfl;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    flags_d.z = (ex_alu_result == '0);
                end
                default: flags_d = flags_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            dst_q    <= '0;
            wen_q    <= 1'b0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            dst_q    <= dst_d;
            wen_q    <= wen_d;
            flags_q  <= flags_d;
        end
    end

    // With bypass, a qualifying flag write is visible to the branch in the same cycle.
    assign flags_eff = (FLAG_BYPASS && flag_upd) ? flags_d : flags_q;

    branch_cond_eval u_cond (
        .flags (flags_eff),
        .cond  (cond_t'(cond_code)),
        .taken (branch_taken)
    );

    assign mem_valid      = valid_q;
    assign mem_alu_result = result_q;
    assign mem_dst_reg    = dst_q;
    assign mem_reg_wen    = wen_q;
    assign flag_z         = flags_q.z;
    assign flag_v         = flags_q.v;
    assign flag_n         = flags_q.n;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Scoreboard bench for ex_mem_flag_stage; one instance without and one with flag bypass.
module tb_ex_mem_flag_stage;

    typedef struct packed {
        logic        v;
        logic [15:0] r;
        logic [3:0]  d;
        logic        w;
        logic        z;
        logic        fv;
        logic        n;
    } st_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid, ex_ovfl, ex_reg_wen;
    logic [3:0]  ex_opcode, ex_dst_reg;
    logic [15:0] ex_alu_result;
    logic [2:0]  cond_code;

    logic        mem_valid0, mem_reg_wen0, flag_z0, flag_v0, flag_n0, taken0;
    logic [15:0] mem_alu_result0;
    logic [3:0]  mem_dst_reg0;
    logic        mem_valid1, mem_reg_wen1, flag_z1, flag_v1, flag_n1, taken1;
    logic [15:0] mem_alu_result1;
    logic [3:0]  mem_dst_reg1;

    st_t obs0, obs1, m, e;
    st_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    ex_mem_flag_stage #(.DATA_W(16), .REG_ADDR_W(4), .FLAG_BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result), .ex_ovfl(ex_ovfl),
        .ex_dst_reg(ex_dst_reg), .ex_reg_wen(ex_reg_wen), .cond_code(cond_code),
        .mem_valid(mem_valid0), .mem_alu_result(mem_alu_result0), .mem_dst_reg(mem_dst_reg0),
        .mem_reg_wen(mem_reg_wen0), .flag_z(flag_z0), .flag_v(flag_v0), .flag_n(flag_n0),
        .branch_taken(taken0));

    ex_mem_flag_stage #(.DATA_W(16), .REG_ADDR_W(4), .FLAG_BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result), .ex_ovfl(ex_ovfl),
        .ex_dst_reg(ex_dst_reg), .ex_reg_wen(ex_reg_wen), .cond_code(cond_code),
        .mem_valid(mem_valid1), .mem_alu_result(mem_alu_result1), .mem_dst_reg(mem_dst_reg1),
        .mem_reg_wen(mem_reg_wen1), .flag_z(flag_z1), .flag_v(flag_v1), .flag_n(flag_n1),
        .branch_taken(taken1));

    assign obs0 = {mem_valid0, mem_alu_result0, mem_dst_reg0, mem_reg_wen0, flag_z0, flag_v0, flag_n0};
    assign obs1 = {mem_valid1, mem_alu_result1, mem_dst_reg1, mem_reg_wen1, flag_z1, flag_v1, flag_n1};

    // Reference branch condition table.
    function automatic logic cond_ref(input logic [2:0] c, input logic z, input logic v, input logic n);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Drive one cycle of EX inputs, advance the model, push the expected MEM state, take the edge.
    task automatic cyc(input logic r, input logic s, input logic f, input logic v,
                       input logic [3:0] op, input logic [15:0] res, input logic ov,
                       input logic [3:0] d, input logic w);
        rst = r; stall = s; flush = f; ex_valid = v; ex_opcode = op;
        ex_alu_result = res; ex_ovfl = ov; ex_dst_reg = d; ex_reg_wen = w;
        if (r) m = '0;
        else if (f) begin
            m.v = 1'b0; m.w = 1'b0;
        end else if (!s) begin
            m.v = v; m.r = res; m.d = d; m.w = w & v;
            if (v) begin
                if (op == 4'h0 || op == 4'h1) begin
                    m.z = (res == 16'h0); m.n = res[15]; m.fv = ov;
                end else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) begin
                    m.z = (res == 16'h0);
                end
            end
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cond_code = 3'd0;
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 1, 4'h0, 16'h0000, 0, 4'd0, 1);
            e = sb.pop_front(); n_chk++;
            if (obs0 !== e) begin n_fail++; $display("FAIL reset_stage0 got %h want %h", obs0, e); end
            n_chk++;
            if (obs1 !== 25'h0) begin n_fail++; $display("FAIL reset_stage1 got %h want 0", obs1); end
        end
        rst = 1'b0; ex_valid = 1'b0;
        #1;
        n_chk++;
        if ({flag_z0, flag_v0, flag_n0} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {flag_z0, flag_v0, flag_n0});
        end
    endtask

    task automatic test_add();
        cyc(0, 0, 0, 1, 4'h0, 16'h8000, 1, 4'd5, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL add_stage got %h want %h", obs0, e); end
        n_chk++;
        if ({mem_valid0, mem_alu_result0, mem_dst_reg0, mem_reg_wen0} !== {1'b1, 16'h8000, 4'd5, 1'b1}) begin
            n_fail++; $display("FAIL add_mem got %h want %h", {mem_valid0, mem_alu_result0, mem_dst_reg0, mem_reg_wen0}, {1'b1, 16'h8000, 4'd5, 1'b1});
        end
        n_chk++;
        if ({flag_z0, flag_v0, flag_n0} !== 3'b011) begin
            n_fail++; $display("FAIL add_flags got %b want 011", {flag_z0, flag_v0, flag_n0});
        end
        ex_valid = 1'b0;
        cond_code = 3'b011; #1; n_chk++;
        if (taken0 !== 1'b1) begin n_fail++; $display("FAIL add_lt got %b want 1", taken0); end
        cond_code = 3'b110; #1; n_chk++;
        if (taken0 !== 1'b1) begin n_fail++; $display("FAIL add_ovfl got %b want 1", taken0); end
    endtask

    task automatic test_sub_xor();
        cyc(0, 0, 0, 1, 4'h1, 16'h0000, 0, 4'd2, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL sub_stage got %h want %h", obs0, e); end
        n_chk++;
        if ({flag_z0, flag_v0, flag_n0} !== 3'b100) begin
            n_fail++; $display("FAIL sub_flags got %b want 100", {flag_z0, flag_v0, flag_n0});
        end
        cyc(0, 0, 0, 1, 4'h2, 16'h00FF, 1, 4'd3, 1);
        e = sb.pop_front(); n_chk++;
        if (obs1 !== e) begin n_fail++; $display("FAIL xor_stage got %h want %h", obs1, e); end
        n_chk++;
        if ({flag_z0, flag_v0, flag_n0} !== 3'b000) begin
            n_fail++; $display("FAIL xor_flags got %b want 000", {flag_z0, flag_v0, flag_n0});
        end
        ex_valid = 1'b0; cond_code = 3'b010; #1; n_chk++;
        if (taken0 !== 1'b1) begin n_fail++; $display("FAIL xor_gt got %b want 1", taken0); end
    endtask

    task automatic test_no_flag_ops();
        cyc(0, 0, 0, 1, 4'h0, 16'h8000, 0, 4'd1, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL setn_stage got %h want %h", obs0, e); end
        cyc(0, 0, 0, 1, 4'h3, 16'h0000, 1, 4'd4, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL red_stage got %h want %h", obs0, e); end
        cyc(0, 0, 0, 1, 4'h7, 16'h0000, 1, 4'd6, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL paddsb_stage got %h want %h", obs0, e); end
        n_chk++;
        if ({flag_z0, flag_v0, flag_n0} !== 3'b001) begin
            n_fail++; $display("FAIL noflag_flags got %b want 001", {flag_z0, flag_v0, flag_n0});
        end
        ex_valid = 1'b0; cond_code = 3'b101; #1; n_chk++;
        if (taken0 !== 1'b1) begin n_fail++; $display("FAIL noflag_lte got %b want 1", taken0); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 4'h0, 16'h0000, 0, 4'd3, 1);
            e = sb.pop_front(); n_chk++;
            if (obs0 !== e) begin n_fail++; $display("FAIL stall_stage0 got %h want %h", obs0, e); end
            n_chk++;
            if (obs1 !== e) begin n_fail++; $display("FAIL stall_stage1 got %h want %h", obs1, e); end
        end
        n_chk++;
        if (flag_z0 !== 1'b0 || mem_dst_reg0 !== 4'd6) begin
            n_fail++; $display("FAIL stall_frozen got z=%b dst=%0d want z=0 dst=6", flag_z0, mem_dst_reg0);
        end
        cyc(0, 0, 0, 1, 4'h0, 16'h0000, 0, 4'd3, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL stall_release got %h want %h", obs0, e); end
        n_chk++;
        if (flag_z0 !== 1'b1 || mem_dst_reg0 !== 4'd3) begin
            n_fail++; $display("FAIL stall_capture got z=%b dst=%0d want z=1 dst=3", flag_z0, mem_dst_reg0);
        end
    endtask

    task automatic test_flush();
        cyc(0, 0, 0, 1, 4'h0, 16'h1234, 0, 4'd8, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL preflush_stage got %h want %h", obs0, e); end
        // flush + stall: bypass instance must still see old z=0
        rst = 0; stall = 1; flush = 1; ex_valid = 1; ex_opcode = 4'h0;
        ex_alu_result = 16'h0000; cond_code = 3'b001; #1;
        n_chk++;
        if (taken1 !== 1'b0) begin n_fail++; $display("FAIL flush_bypass_eq got %b want 0", taken1); end
        n_chk++;
        if (taken0 !== 1'b0) begin n_fail++; $display("FAIL flush_eq got %b want 0", taken0); end
        cyc(0, 1, 1, 1, 4'h0, 16'h0000, 0, 4'd9, 1);
        e = sb.pop_front(); n_chk++;
        if (obs1 !== e) begin n_fail++; $display("FAIL flush_stall_stage got %h want %h", obs1, e); end
        n_chk++;
        if ({mem_valid0, mem_reg_wen0, flag_z0} !== 3'b000) begin
            n_fail++; $display("FAIL flush_stall_out got %b want 000", {mem_valid0, mem_reg_wen0, flag_z0});
        end
        cyc(0, 0, 1, 1, 4'h1, 16'h0000, 1, 4'd9, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL flush_only_stage got %h want %h", obs0, e); end
    endtask

    task automatic test_bypass();
        rst = 0; stall = 0; flush = 0; ex_valid = 1; ex_opcode = 4'h0;
        ex_alu_result = 16'h0000; ex_ovfl = 0; cond_code = 3'b001; #1;
        n_chk++;
        if (taken1 !== 1'b1) begin n_fail++; $display("FAIL bypass_eq got %b want 1", taken1); end
        n_chk++;
        if (taken0 !== 1'b0) begin n_fail++; $display("FAIL nobypass_eq got %b want 0", taken0); end
        cyc(0, 0, 0, 1, 4'h0, 16'h0000, 0, 4'd10, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL bypass_stage got %h want %h", obs0, e); end
        ex_valid = 1'b0; #1; n_chk++;
        if (taken0 !== 1'b1) begin n_fail++; $display("FAIL post_bypass_eq got %b want 1", taken0); end
    endtask

    task automatic test_cond_table();
        cyc(0, 0, 0, 1, 4'h0, 16'h8000, 1, 4'd11, 0);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL ctab_a_stage got %h want %h", obs0, e); end
        ex_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cond_code = 3'(c); #1; n_chk++;
            if (taken0 !== cond_ref(3'(c), 1'b0, 1'b1, 1'b1)) begin
                n_fail++; $display("FAIL ctab_a cond=%0d got %b want %b", c, taken0, cond_ref(3'(c), 1'b0, 1'b1, 1'b1));
            end
        end
        cyc(0, 0, 0, 1, 4'h1, 16'h0000, 0, 4'd12, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL ctab_b_stage got %h want %h", obs0, e); end
        ex_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cond_code = 3'(c); #1; n_chk++;
            if (taken1 !== cond_ref(3'(c), 1'b1, 1'b0, 1'b0)) begin
                n_fail++; $display("FAIL ctab_b cond=%0d got %b want %b", c, taken1, cond_ref(3'(c), 1'b1, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc(0, 0, 0, 1, 4'h1, 16'h8000, 1, 4'd1, 1);
        cyc(0, 0, 0, 1, 4'h2, 16'h0000, 0, 4'd2, 1);
        e = sb.pop_front(); n_chk++;
        if (e.r !== 16'h8000) begin n_fail++; $display("FAIL b2b_order got %h want 8000", e.r); end
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL b2b_stage got %h want %h", obs0, e); end
        n_chk++;
        if ({flag_z0, flag_v0, flag_n0} !== 3'b111) begin
            n_fail++; $display("FAIL b2b_flags got %b want 111", {flag_z0, flag_v0, flag_n0});
        end
        cyc(0, 0, 0, 0, 4'h0, 16'h0005, 0, 4'd7, 1);
        e = sb.pop_front(); n_chk++;
        if (obs0 !== e) begin n_fail++; $display("FAIL invalid_stage got %h want %h", obs0, e); end
        n_chk++;
        if ({mem_valid0, mem_reg_wen0} !== 2'b00) begin
            n_fail++; $display("FAIL invalid_wen got %b want 00", {mem_valid0, mem_reg_wen0});
        end
    endtask

    initial begin
        m = '0;
        rst = 1; stall = 0; flush = 0; ex_valid = 0; ex_opcode = 0;
        ex_alu_result = 0; ex_ovfl = 0; ex_dst_reg = 0; ex_reg_wen = 0; cond_code = 0;
        test_reset();
        test_add();
        test_sub_xor();
        test_no_flag_ops();
        test_stall();
        test_flush();
        test_bypass();
        test_cond_table();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
